da2_dac: RTL and testbench

SPI transmitter for the Pmod DA2 (two DAC121S101 12-bit DACs sharing SCLK and SYNC, one data line each). It is the output-side counterpart of the MIC3 ADC reader: it takes two parallel 12-bit samples plus power-down modes from the user logic and serialises them into one simultaneous 16-bit frame per channel. It sits between the audio/sample datapath and the Pmod pins, and uses the same single-clock, divided-SCLK style as the ADC reader.

---
 rtl/da2_pkg.sv | 26 ++
 rtl/da2_clkgen.sv | 51 +++++
 rtl/da2_dac.sv | 115 +++++++++++
 tb/tb_da2_dac.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da2_pkg.sv
// Shared definitions for the Pmod DA2 transmitter: frame geometry, power-down
// mode codes, FSM state encoding and the frame word packing rule.
package da2_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // DAC121S101 word: two don't-care zeros, power-down mode, then the sample
    function automatic logic [FRAME_BITS-1:0] frameWord(input logic [1:0]           mode,
                                                        input logic [DATA_BITS-1:0] data);
        return {2'b00, mode, data};
    endfunction

endpackage

// File: rtl/da2_clkgen.sv
// SCLK generator: divides the system clock into bit periods that start with
// SCLK high, and flags the end of each period and of the final bit.
module da2_clkgen
    import da2_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [BIT_CNT_W-1:0] bitCnt_i,
    output logic                 sclk_o,
    output logic                 bitStart_o,
    output logic                 lastBit_o
);

    localparam int CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int HALF = CLK_DIV / 2;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          periodEnd;

    // SCLK is decoded from the next count and registered, so it is glitch-free
    // and automatically returns high whenever the counter is held at zero.
    always_comb begin
        periodEnd = en_i && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d     = '0;
        if (en_i && !periodEnd) begin
            cnt_d = cnt_q + 1'b1;
        end
        sclk_d = (cnt_d < CW'(HALF));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    // bitStart is high in the cycle whose closing edge opens the next period
    assign sclk_o     = sclk_q;
    assign bitStart_o = periodEnd && (bitCnt_i != LAST_BIT);
    assign lastBit_o  = periodEnd && (bitCnt_i == LAST_BIT);

endmodule

// File: rtl/da2_dac.sv
// Pmod DA2 transmitter: latches two 12-bit samples with power-down modes and
// shifts them out MSB first as simultaneous 16-bit frames on D0/D1.
module da2_dac
    import da2_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SYNC_GAP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 SCLK,
    output logic                 SYNC,
    output logic                 D0,
    output logic                 D1,
    input  logic [DATA_BITS-1:0] data0,
    input  logic [DATA_BITS-1:0] data1,
    input  logic [1:0]           mode0,
    input  logic [1:0]           mode1,
    input  logic                 update,
    output logic                 busy,
    output logic                 done
);

    localparam int GW = $clog2(SYNC_GAP + 1);

    state_t                  state_q;
    logic [FRAME_BITS-1:0]   shift0_q, shift1_q;
    logic [BIT_CNT_W-1:0]    bitCnt_q;
    logic [GW-1:0]           gapCnt_q;
    logic                    sync_q, d0_q, d1_q, busy_q, done_q;
    logic                    bitStart, lastBit;
    logic [FRAME_BITS-1:0]   word0, word1;

    assign word0 = frameWord(mode0, data0);
    assign word1 = frameWord(mode1, data1);

    da2_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (state_q == ST_SHIFT),
        .bitCnt_i   (bitCnt_q),
        .sclk_o     (SCLK),
        .bitStart_o (bitStart),
        .lastBit_o  (lastBit)
    );

    // Data outputs are loaded with bit 15 on accept and then advanced only at
    // period boundaries, which is always while SCLK is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift0_q <= '0;
            shift1_q <= '0;
            bitCnt_q <= '0;
            gapCnt_q <= '0;
            sync_q   <= 1'b1;
            d0_q     <= 1'b0;
            d1_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (update) begin
                        state_q  <= ST_SHIFT;
                        shift0_q <= word0;
                        shift1_q <= word1;
                        d0_q     <= word0[FRAME_BITS-1];
                        d1_q     <= word1[FRAME_BITS-1];
                        bitCnt_q <= '0;
                        sync_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (lastBit) begin
                        state_q  <= ST_GAP;
                        gapCnt_q <= '0;
                        sync_q   <= 1'b1;
                        d0_q     <= 1'b0;
                        d1_q     <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (bitStart) begin
                        shift0_q <= shift0_q << 1;
                        shift1_q <= shift1_q << 1;
                        d0_q     <= shift0_q[FRAME_BITS-2];
                        d1_q     <= shift1_q[FRAME_BITS-2];
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gapCnt_q == GW'(SYNC_GAP - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SYNC = sync_q;
    assign D0   = d0_q;
    assign D1   = d1_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_da2_dac.sv
// Scoreboard bench for da2_dac: stimulus queues expected frame words, a
// monitor decodes SCLK/SYNC/D0/D1 and checks words and frame timing.
module tb_da2_dac;
    import da2_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] data0, data1;
    logic [1:0]  mode0, mode1;
    logic        update;
    logic        SCLK, SYNC, D0, D1, busy, done;

    logic [11:0] bData0, bData1;
    logic [1:0]  bMode0, bMode1;
    logic        bUpdate;
    logic        bSclk, bSync, bD0, bD1, bBusy, bDone;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
    } frame_t;

    frame_t expQ[$];
    int     vectors     = 0;
    int     miscompares = 0;
    bit     monEn        = 1'b0;
    bit     abortPending = 1'b0;
    bit     streaming    = 1'b0;
    int     streamFalls  = 0;

    always #5 clk = ~clk;

    da2_dac dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .SYNC(SYNC), .D0(D0), .D1(D1),
        .data0(data0), .data1(data1), .mode0(mode0), .mode1(mode1),
        .update(update), .busy(busy), .done(done)
    );

    da2_dac #(.CLK_DIV(2), .SYNC_GAP(1)) dutB (
        .clk(clk), .rst(rst), .SCLK(bSclk), .SYNC(bSync), .D0(bD0), .D1(bD1),
        .data0(bData0), .data1(bData1), .mode0(bMode0), .mode1(bMode1),
        .update(bUpdate), .busy(bBusy), .done(bDone)
    );

    function automatic logic [15:0] modelWord(input logic [1:0] m, input logic [11:0] d);
        return 16'(m) * 16'd4096 + 16'(d);
    endfunction

    function automatic logic [1:0] pickMode(input int idx);
        case (idx)
            0:       return PD_NORMAL;
            1:       return PD_1K;
            2:       return PD_100K;
            default: return PD_HIZ;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] d0, input logic [1:0] m0,
                                 input logic [11:0] d1, input logic [1:0] m1,
                                 input int changeAt);
        data0  = d0;
        mode0  = m0;
        data1  = d1;
        mode1  = m1;
        update = 1'b1;
        expQ.push_back('{w0: modelWord(m0, d0), w1: modelWord(m1, d1)});
        @(negedge clk);
        update = 1'b0;
        if (changeAt > 0) begin
            repeat (changeAt - 1) @(negedge clk);
            data0 = 12'hFFF;
            mode0 = ~m0;
            data1 = ~d1;
        end
        waitIdle();
    endtask

    // Monitor: decodes frames on the pins of the default-parameter instance
    int          cycle = 0, syncLow = 0, falls = 0, sinceRise = 0, highRun = 0, lastRise = -1;
    logic [15:0] cap0 = '0, cap1 = '0;
    logic        prevSync = 1'b1, prevSclk = 1'b1, prevBusy = 1'b0;
    bit          riseSeen = 1'b0;

    always @(negedge clk) begin
        bit     rise, fall;
        frame_t e;
        cycle++;
        if (monEn) begin
            rise = (prevSync === 1'b0) && (SYNC === 1'b1);
            fall = (prevSync === 1'b1) && (SYNC === 1'b0);
            if (SYNC === 1'b0) begin
                syncLow++;
                if (prevSclk === 1'b1 && SCLK === 1'b0) begin
                    cap0 = {cap0[14:0], D0};
                    cap1 = {cap1[14:0], D1};
                    falls++;
                    if (streaming) streamFalls++;
                end
            end
            if (rise) begin
                checkOutput("frame expected by scoreboard", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    if (abortPending) begin
                        checkOutput("abort SCLK/D0/D1/busy/done", {SCLK, D0, D1, busy, done}, 5'b10000);
                        abortPending = 1'b0;
                        riseSeen     = 1'b0;
                    end else begin
                        checkOutput("D0 word", cap0, e.w0);
                        checkOutput("D1 word", cap1, e.w1);
                        checkOutput("SCLK falls per frame", falls, 16);
                        checkOutput("SYNC low cycles", syncLow, 64);
                        checkOutput("done at frame end", done, 1);
                        checkOutput("idle pins at frame end", {SCLK, D0, D1}, 3'b100);
                        if (streaming && lastRise >= 0)
                            checkOutput("SYNC rise spacing", cycle - lastRise, 69);
                        lastRise = streaming ? cycle : -1;
                        riseSeen = 1'b1;
                    end
                end
                syncLow   = 0;
                falls     = 0;
                cap0      = '0;
                cap1      = '0;
                sinceRise = 0;
                highRun   = 0;
            end else begin
                if (done === 1'b1) checkOutput("done without frame end", done, 0);
                if (riseSeen) begin
                    sinceRise++;
                    if (prevBusy === 1'b1 && busy === 1'b0) begin
                        checkOutput("busy fall after done", sinceRise, 4);
                        riseSeen = 1'b0;
                    end
                end
            end
            if (SYNC === 1'b1) highRun++;
            if (fall) begin
                if (streaming && lastRise >= 0) checkOutput("SYNC high gap", highRun, 5);
                highRun = 0;
            end
        end
        prevSync = SYNC;
        prevSclk = SCLK;
        prevBusy = busy;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [11:0] rd0, rd1;
        logic [1:0]  rm0, rm1;
        logic [15:0] bExp0, bExp1, bCap0, bCap1;
        int          bLow, bHi, bLo, bFalls;
        logic        bPrevSclk;

        rst = 1'b1; update = 1'b0;
        data0 = '0; data1 = '0; mode0 = '0; mode1 = '0;
        bData0 = '0; bData1 = '0; bMode0 = '0; bMode1 = '0; bUpdate = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("reset outputs", {SYNC, SCLK, D0, D1, busy, done, bSync, bSclk, bBusy}, 9'b110000110);
            @(negedge clk);
        end
        rst   = 1'b0;
        monEn = 1'b1;
        @(negedge clk);

        $display("[TB] single frame");
        applyStimulus(12'hA5C, PD_NORMAL, 12'h3F0, PD_HIZ, 0);

        $display("[TB] input change mid-frame");
        applyStimulus(12'hA5C, PD_NORMAL, 12'h3F0, PD_HIZ, 20);

        $display("[TB] random frames");
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            applyStimulus(12'($urandom), pickMode($urandom_range(0, 3)),
                          12'($urandom), pickMode($urandom_range(0, 3)), 0);
        end

        $display("[TB] streaming");
        streaming   = 1'b1;
        streamFalls = 0;
        for (int k = 0; k < 3; k++) begin
            rd0 = 12'($urandom); rd1 = 12'($urandom);
            rm0 = pickMode($urandom_range(0, 3)); rm1 = pickMode($urandom_range(0, 3));
            data0 = rd0; data1 = rd1; mode0 = rm0; mode1 = rm1;
            expQ.push_back('{w0: modelWord(rm0, rd0), w1: modelWord(rm1, rd1)});
            update = 1'b1;
            repeat (10) @(negedge clk);
            if (k == 2) update = 1'b0;
            else        repeat (59) @(negedge clk);
        end
        waitIdle();
        streaming = 1'b0;
        checkOutput("streaming falls total", streamFalls, 48);

        $display("[TB] reset mid-frame");
        rd0 = 12'($urandom); rd1 = 12'($urandom);
        data0 = rd0; data1 = rd1; mode0 = PD_1K; mode1 = PD_100K;
        expQ.push_back('{w0: modelWord(PD_1K, rd0), w1: modelWord(PD_100K, rd1)});
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        repeat (29) @(negedge clk);
        abortPending = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(12'($urandom), PD_100K, 12'($urandom), PD_NORMAL, 0);

        $display("[TB] reset and update together");
        rst = 1'b1; update = 1'b1;
        @(negedge clk);
        rst = 1'b0; update = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset beats update", {SYNC, busy}, 2'b10);
            @(negedge clk);
        end

        $display("[TB] CLK_DIV=2 instance");
        bData0 = 12'h001; bMode0 = pickMode($urandom_range(0, 3));
        bData1 = 12'($urandom); bMode1 = pickMode($urandom_range(0, 3));
        bExp0 = modelWord(bMode0, bData0);
        bExp1 = modelWord(bMode1, bData1);
        bUpdate = 1'b1;
        @(negedge clk);
        bUpdate = 1'b0;
        bLow = 0; bHi = 0; bLo = 0; bFalls = 0; bCap0 = '0; bCap1 = '0; bPrevSclk = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bSync === 1'b0) begin
                bLow++;
                if (bSclk === 1'b1) bHi++;
                else                bLo++;
                if (bPrevSclk === 1'b1 && bSclk === 1'b0) begin
                    bCap0 = {bCap0[14:0], bD0};
                    bCap1 = {bCap1[14:0], bD1};
                    bFalls++;
                end
            end else if (bLow > 0) begin
                break;
            end
            bPrevSclk = bSclk;
            @(negedge clk);
        end
        checkOutput("div2 SYNC low cycles", bLow, 32);
        checkOutput("div2 SCLK high cycles", bHi, 16);
        checkOutput("div2 SCLK low cycles", bLo, 16);
        checkOutput("div2 falls", bFalls, 16);
        checkOutput("div2 D0 word", bCap0, bExp0);
        checkOutput("div2 D1 word", bCap1, bExp1);
        checkOutput("div2 D0 bit0 on 16th fall", bCap0[0], 1);
        repeat (5) @(negedge clk);

        checkOutput("frames left in scoreboard", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
